// File: rtl/fsm_pht_pkg.sv
// Shared definitions for the pattern history table: counter encoding,
// default table size and the saturating step function.
package fsm_pht_pkg;

    // Default number of index bits taken from the training address
    localparam int PHT_INDEX_BITS = 10;

    // Two-bit saturating counter type and its state encoding
    typedef logic [1:0] ctr2_t;

    localparam ctr2_t SNT = 2'b00;  // strong not-taken
    localparam ctr2_t WNT = 2'b01;  // weak not-taken
    localparam ctr2_t WT  = 2'b10;  // weak taken
    localparam ctr2_t ST  = 2'b11;  // strong taken

    // One saturating step: towards ST when up=1, towards SNT when up=0
    function automatic ctr2_t sat_step(input ctr2_t cur, input logic up);
        ctr2_t nxt;
        case (cur)
            SNT:     nxt = up ? WNT : SNT;
            WNT:     nxt = up ? WT  : SNT;
            WT:      nxt = up ? ST  : WNT;
            ST:      nxt = up ? ST  : WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Single 2-bit saturating up/down counter with a synchronous active-low
// reset that loads a caller-supplied initial value.
module sat_counter2
    import fsm_pht_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic [1:0] init,
    output logic [1:0] cnt
);

    ctr2_t r_cnt;
    ctr2_t w_next;

    // Next count: step when enabled, otherwise hold
    always_comb begin
        w_next = r_cnt;
        if (en) begin
            w_next = sat_step(r_cnt, up);
        end else begin
            w_next = r_cnt;
        end
    end

    // Counter register; reset has priority over any step in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= init;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/fsm_pht.sv
// Pattern history table: an array of 2-bit saturating counters trained by
// the resolved branch outcome, with every counter MSB exported in parallel
// as a taken/not-taken prediction. Pred is unregistered; the enclosing
// predictor provides its own register stage.
module fsm_pht
    import fsm_pht_pkg::*;
#(
    parameter int          INDEX_BITS = PHT_INDEX_BITS,
    parameter int          ENTRIES    = 2 ** INDEX_BITS,
    parameter logic [1:0]  CTR_INIT   = WNT
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               isTaken,
    input  logic               isBranch,
    input  logic [31:0]        InstrPC,
    output logic [ENTRIES-1:0] Pred
);

    // Word-aligned index; higher address bits alias onto the same entries
    logic [INDEX_BITS-1:0]         w_idx;
    logic [ENTRIES-1:0][1:0]       w_ctr;
    logic                          w_unused_pc_bits;

    assign w_idx            = InstrPC[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{InstrPC[31:INDEX_BITS+2], InstrPC[1:0]};

    // One counter per entry; only the addressed entry steps on a branch
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        localparam logic [INDEX_BITS-1:0] ENTRY_IDX = INDEX_BITS'(i);
        logic w_en;

        assign w_en = isBranch && (w_idx == ENTRY_IDX);

        sat_counter2 u_ctr (
            .clk   (CLK),
            .rst_n (RESET),
            .en    (w_en),
            .up    (isTaken),
            .init  (CTR_INIT),
            .cnt   (w_ctr[i])
        );

        assign Pred[i] = w_ctr[i][1];
    end

endmodule

// File: tb/tb_fsm_pht.sv
// Self-checking bench for fsm_pht: a table-level model of the counters is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_fsm_pht;

    localparam int N = 1024;

    logic          CLK;
    logic          RESET;
    logic          isTaken;
    logic          isBranch;
    logic [31:0]   InstrPC;
    logic [N-1:0]  Pred;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain integer counters clamped to 0..3
    int model_ctr [N];
    bit model_valid = 1'b0;

    fsm_pht dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .isTaken  (isTaken),
        .isBranch (isBranch),
        .InstrPC  (InstrPC),
        .Pred     (Pred)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model update at each rising edge from the sampled inputs
    always @(posedge CLK) begin
        if (RESET === 1'b0) begin
            foreach (model_ctr[k]) model_ctr[k] <= 1;
            model_valid <= 1'b1;
        end else if (model_valid && isBranch === 1'b1) begin
            int idx;
            idx = int'((InstrPC / 4) % N);
            if (isTaken) model_ctr[idx] <= (model_ctr[idx] >= 3) ? 3 : model_ctr[idx] + 1;
            else         model_ctr[idx] <= (model_ctr[idx] <= 0) ? 0 : model_ctr[idx] - 1;
        end
    end

    // Per-cycle compare on the falling edge, away from the update edge
    always @(negedge CLK) begin
        if (model_valid) begin
            logic [N-1:0] exp_pred;
            int bad_idx;
            bad_idx = -1;
            for (int k = 0; k < N; k++) begin
                exp_pred[k] = (model_ctr[k] >= 2);
                if (bad_idx < 0 && int'(dut.w_ctr[k]) != model_ctr[k]) bad_idx = k;
            end
            checks++;
            if (Pred !== exp_pred) begin
                errors++;
                $display("FAIL model_pred t=%0t got=%h exp=%h", $time, Pred, exp_pred);
            end
            checks++;
            if (bad_idx >= 0) begin
                errors++;
                $display("FAIL model_ctr t=%0t idx=%0d got=%0d exp=%0d",
                         $time, bad_idx, dut.w_ctr[bad_idx], model_ctr[bad_idx]);
            end
        end
    end

    // Directed literal check
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the rising edge
    task automatic cyc(input logic rst, input logic br, input logic tk, input logic [31:0] pc);
        RESET    = rst;
        isBranch = br;
        isTaken  = tk;
        InstrPC  = pc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_vec;
        RESET = 1'b0; isBranch = 1'b0; isTaken = 1'b0; InstrPC = 32'h0;
        #2;

        // Reset held two cycles
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset_pred_zero", int'(Pred == '0), 1);
        chk("reset_ctr0",    int'(dut.w_ctr[0]),    1);
        chk("reset_ctr511",  int'(dut.w_ctr[511]),  1);
        chk("reset_ctr1023", int'(dut.w_ctr[1023]), 1);

        // Train up idx 2 with saturation
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        exp_vec = '0; exp_vec[2] = 1'b1;
        chk("up1_pred_only2", int'(Pred == exp_vec), 1);
        chk("up1_ctr2", int'(dut.w_ctr[2]), 2);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        chk("up2_ctr2", int'(dut.w_ctr[2]), 3);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        chk("up_sat_ctr2", int'(dut.w_ctr[2]), 3);

        // Train down with hysteresis
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0008);
        chk("dn1_ctr2", int'(dut.w_ctr[2]), 2);
        chk("dn1_pred2", int'(Pred[2]), 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0008);
        chk("dn2_ctr2", int'(dut.w_ctr[2]), 1);
        chk("dn2_pred2", int'(Pred[2]), 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0008);
        chk("dn3_ctr2", int'(dut.w_ctr[2]), 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0008);
        chk("dn_sat_ctr2", int'(dut.w_ctr[2]), 0);

        // Enable gating
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h0000_0FFC);
            chk("gate_pred1023", int'(Pred[1023]), 0);
        end
        chk("gate_ctr1023", int'(dut.w_ctr[1023]), 1);

        // Aliasing and ignored low bits
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_1004);
        chk("alias_up_pred1", int'(Pred[1]), 1);
        chk("alias_up_pred0", int'(Pred[0]), 0);
        chk("alias_up_pred2", int'(Pred[2]), 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0007);
        chk("alias_dn_pred1", int'(Pred[1]), 0);
        chk("alias_dn_ctr1", int'(dut.w_ctr[1]), 1);
        chk("alias_dn_ctr0", int'(dut.w_ctr[0]), 1);

        // Reset mid-operation overrides training
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0014);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0014);
        chk("pre_rst_ctr5", int'(dut.w_ctr[5]), 3);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0014);
        chk("mid_rst_ctr5", int'(dut.w_ctr[5]), 1);
        chk("mid_rst_pred5", int'(Pred[5]), 0);
        chk("mid_rst_pred_all", int'(Pred == '0), 1);

        // Random training over a small aliased window, checked by the model
        for (int c = 0; c < 300; c++) begin
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                {$urandom_range(0, 3), 18'h0, 4'($urandom_range(0, 15)), 8'h0}
                | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3)));
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_pht.md
Name: fsm_pht

Overview:
- Pattern history table of 1024 two-bit saturating counters.
- Serves as the second-level predictor inside the local branch predictor (LBP).
- The ID-stage resolved outcome (isBranch/isTaken) trains the counter selected by InstrPC[11:2]. In LBP, InstrPC carries the 10-bit local history shifted left by 2.
- All 1024 per-entry predictions (counter MSBs) are exported in parallel. LBP selects one entry using the IF-stage history.

Parameters:
- INDEX_BITS, 10, number of index bits taken from InstrPC[INDEX_BITS+1:2].
- ENTRIES, 1024 (2**INDEX_BITS), number of counters.
- CTR_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- isTaken  input  1  resolved direction of the branch being trained (1 = taken).
- isBranch  input  1  training enable; 1 means the ID-stage instruction is a branch.
- InstrPC  input  32  training address; bits [11:2] form the counter index, all other bits are ignored.
- Pred  output  ENTRIES  Pred[i] = MSB of counter i (1 = predict taken).

Behaviour:
- State: ctr[0..ENTRIES-1], each 2 bits.
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Reset:
  - At a rising CLK edge with RESET=0, every counter becomes CTR_INIT.
  - All Pred bits therefore read 0 from the following cycle onward.
  - Reset overrides any training in the same cycle.
  - Reset may be asserted mid-operation with the same effect; no partial state is retained.
- Training:
  - Occurs at a rising CLK edge with RESET=1 and isBranch=1.
  - idx = InstrPC[11:2].
  - isTaken=1: ctr[idx] <= ctr[idx]+1, saturating at 11.
  - isTaken=0: ctr[idx] <= ctr[idx]-1, saturating at 00.
  - Exactly one counter changes per cycle; all others hold.
- isBranch=0: no counter changes, regardless of isTaken or InstrPC.
- Output:
  - Pred is a purely combinational function of the counter registers; there is no output register.
  - A training update appears on Pred one cycle after the edge that writes it.
  - No bypass: Pred during the cycle of a write still shows the old value.
  - The enclosing LBP adds its own register stage.
- Wrap-around: InstrPC bits above 11 alias.
  - Example: 0x0000_0004 and 0x0000_1004 both map to index 1.
  - InstrPC[1:0] are ignored.
- No handshake and no X-propagation concerns. Inputs are assumed stable around the clock edge, as in the other pipeline blocks.
- Implementation:
  - Counters are a flat register array with per-entry next-state logic, or a single indexed write.
  - The full array must be readable in parallel for Pred.

Decomposition:
- Shared package contents:
  - Counter state encoding constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - INDEX_BITS default.
  - Typedef for a 2-bit counter.
- Natural sub-module: sat_counter2, a single 2-bit saturating up/down counter.
  - Inputs: clk, rst_n, en, up, init.
  - Output: cnt.
  - Instantiate it ENTRIES times via generate, with en = isBranch && (idx == i).

Test Plan:
- Reset: hold RESET=0 for 2 cycles, then release.
  - Required: every Pred bit = 0.
  - Required: internal ctr[0], ctr[511], ctr[1023] all = 01.
- Train up: InstrPC=0x0000_0008 (idx 2), isBranch=1, isTaken=1 for 1 cycle.
  - Required: Pred[2]=1 on the next cycle; all other Pred bits = 0.
  - One further taken cycle: ctr[2]=11.
  - Two more taken cycles: ctr[2] stays 11 (saturation).
- Train down with hysteresis: from ctr[2]=11, apply 1 not-taken cycle.
  - Required: ctr=10, Pred[2]=1.
  - Second not-taken: ctr=01, Pred[2]=0.
  - Third and fourth not-taken: ctr=00, then holds 00.
- Enable gating: isBranch=0, isTaken=1, InstrPC=0x0000_0FFC for 5 cycles.
  - Required: Pred[1023] stays 0; no counter changes.
- Aliasing and index decoding:
  - Train InstrPC=0x0000_1004 taken once: Pred[1]=1.
  - Then train InstrPC=0x0000_0007 (idx 1) not-taken once: Pred[1]=0.
  - Required: Pred[0] and Pred[2] unchanged throughout.
- Reset mid-operation: set ctr[5]=11, then apply RESET=0 in the same cycle as isBranch=1, isTaken=1, idx=5.
  - Required: ctr[5]=01 and Pred[5]=0 after the edge.
